icache_refill_ctrl: RTL
=======================

// Module: icache_refill_ctrl
// PURPOSE
//  Sequences instruction-cache line refills on a fetch-stage miss. Watches the
//  cache miss flag and stalls fetch. Issues one burst request per line to the
//  backing instruction memory. Streams returned words into the cache data array,
//  then pulses the line-replace enable so tag/valid are committed.
//  Sits between the fetch-stage cache and the memory bus; owns the fetch stall.
// PARAMETERS
//  ADDR_W      32  byte-address width
//  DATA_W      32  instruction word width
//  LINE_WORDS  4   words per cache line (power of 2, >=2)
// PORTS
//  clk_i            in   1                   clock; all state on rising edge
//  reset_n_i        in   1                   async active-low reset
//  instr_miss_f_i   in   1                   fetch-stage lookup missed this cycle
//  pc_f_i           in   ADDR_W              fetch address of the missing instr
//  abort_i          in   1                   fetch redirect; cancels an ungranted request
//  mem_req_o        out  1                   burst request valid
//  mem_addr_o       out  ADDR_W              line-aligned burst base address
//  mem_gnt_i        in   1                   request accepted (req & gnt = handshake)
//  mem_rvalid_i     in   1                   one returned word valid
//  mem_rdata_i      in   DATA_W              returned word, in ascending address order
//  fill_we_o        out  1                   write fill_data_o into cache data array
//  fill_idx_o       out  $clog2(LINE_WORDS)  word index within line being written
//  fill_data_o      out  DATA_W              word to write (= mem_rdata_i)
//  fill_addr_o      out  ADDR_W              latched line base (tag/index source)
//  instr_cache_rep_en_o  out 1               1-cycle pulse: commit tag, set valid
//  stall_f_o        out  1                   hold PC/fetch register
//  miss_count_o     out  32                  saturating count of refills started
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, beat counter=0,
//    fill_addr_o=0, miss_count_o=0. All request/write/pulse outputs are 0.
//  - stall_f_o = (state!=IDLE) | instr_miss_f_i. It is combinational, so the miss cycle stalls.
//  - IDLE: on instr_miss_f_i, latch fill_addr_o = {pc_f_i[ADDR_W-1:OFF], OFF'b0} with
//    OFF=$clog2(LINE_WORDS*DATA_W/8). Increment miss_count_o (saturating at 2^32-1). Go to REQ.
//  - REQ: mem_req_o=1, mem_addr_o=fill_addr_o, both held stable until gnt.
//    - req&gnt -> FILL, counter=0.
//    - abort_i & !gnt -> IDLE with no write. abort_i and gnt in the same cycle: grant wins -> FILL.
//  - FILL: each cycle with mem_rvalid_i:
//    - fill_we_o=1, fill_idx_o=counter, fill_data_o=mem_rdata_i, counter++.
//    - Gaps (rvalid=0) are allowed: no write, counter holds.
//    - The beat with counter==LINE_WORDS-1 -> COMMIT; the counter wraps to 0.
//    - abort_i is ignored in FILL: the burst cannot be cancelled and the data is valid.
//  - COMMIT: instr_cache_rep_en_o=1 for exactly one cycle, then IDLE. stall_f_o stays 1
//    through COMMIT, so the first unstalled fetch re-looks up and hits.
//  - mem_rvalid_i outside FILL is ignored (no write). Bench asserts it never occurs.
//  - mem_addr_o=0 when mem_req_o=0. fill_idx_o/fill_data_o are don't-care when fill_we_o=0.
//  - Min miss penalty with gnt in REQ's first cycle and back-to-back rvalid:
//    1 (REQ) + LINE_WORDS (FILL) + 1 (COMMIT) = LINE_WORDS+2 cycles after the miss cycle.
//  - instr_miss_f_i while not IDLE is ignored; there is one outstanding refill only.
//  - Async reset mid-refill: return to IDLE immediately, drop mem_req_o. The partially
//    written line stays invalid because rep_en never pulsed.
// STRUCTURE
//  - icache_pkg (shared with cache and memory model):
//    - typedef enum logic [1:0] {IDLE, REQ, FILL, COMMIT} refill_state_t.
//    - localparams LINE_WORDS, LINE_OFF_W, DATA_W.
//  - Single module: one state register, beat counter and address latch. No sub-module
//    is needed; the beat counter stays inline.
// TESTING
//  - Reset values: hold reset_n_i=0, then release -> all outputs 0, stall_f_o=0 with miss=0.
//  - Clean miss:
//    - Stimulus: pc=0x0000_0124, gnt in the first REQ cycle, 4 back-to-back rvalid words
//      0xA0..0xA3.
//    - Response: mem_addr_o=0x0000_0120; fill_idx 0,1,2,3 with matching data;
//      rep_en pulses once at cycle 6 after the miss; stall drops cycle 7; miss_count=1.
//  - Delayed grant plus rvalid gaps: gnt after 3 cycles, rvalid pattern 1,0,1,1,0,1 ->
//    addr stable while req waits; exactly 4 writes, idx 0..3; one rep_en; stall covers all.
//  - Abort before grant: miss, then abort_i in the 2nd REQ cycle with gnt=0 -> IDLE next cycle,
//    no fill_we_o, no rep_en. Abort with gnt in the same cycle -> full refill proceeds.
//  - Reset mid-FILL: assert reset_n_i after 2 beats -> req/we/rep_en=0 at once; next miss
//    restarts at idx 0.
//  - Back-to-back misses:
//    - Stimulus: keep instr_miss_f_i=1 during the refill, then a new miss at pc=0x0000_0200
//      one cycle after returning to IDLE.
//    - Response: exactly one request per line; second mem_addr_o=0x0000_0200; miss_count=2.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared instruction-cache definitions: refill FSM states and line geometry.
package icache_pkg;
  typedef enum logic [1:0] {IDLE, REQ, FILL, COMMIT} refill_state_t;

  localparam int LINE_WORDS = 4;
  localparam int DATA_W     = 32;
  localparam int LINE_OFF_W = $clog2(LINE_WORDS * DATA_W / 8);
endpackage

// File: rtl/icache_refill_ctrl.sv
// I-cache line refill sequencer: stalls fetch on a miss, issues one burst per line,
// streams returned words into the data array, then pulses the line-replace enable.
module icache_refill_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = icache_pkg::DATA_W,
  parameter int LINE_WORDS = icache_pkg::LINE_WORDS
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          instr_miss_f_i,
  input  logic [ADDR_W-1:0]             pc_f_i,
  input  logic                          abort_i,
  output logic                          mem_req_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  input  logic                          mem_gnt_i,
  input  logic                          mem_rvalid_i,
  input  logic [DATA_W-1:0]             mem_rdata_i,
  output logic                          fill_we_o,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx_o,
  output logic [DATA_W-1:0]             fill_data_o,
  output logic [ADDR_W-1:0]             fill_addr_o,
  output logic                          instr_cache_rep_en_o,
  output logic                          stall_f_o,
  output logic [31:0]                   miss_count_o
);
  import icache_pkg::*;

  localparam int                IDX_W    = $clog2(LINE_WORDS);
  localparam int                OFF      = $clog2(LINE_WORDS * DATA_W / 8);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF) - 64'd1);

  refill_state_t    state, state_nxt;
  logic [IDX_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_nxt;
  end

  // Grant beats abort in REQ; abort has no effect once the burst is accepted.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (instr_miss_f_i) state_nxt = REQ;
      REQ:     if (mem_gnt_i) state_nxt = FILL;
               else if (abort_i) state_nxt = IDLE;
      FILL:    if (mem_rvalid_i && cnt == LAST_IDX) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o            = (state == REQ);
    mem_addr_o           = (state == REQ) ? fill_addr_o : '0;
    fill_we_o            = (state == FILL) && mem_rvalid_i;
    fill_idx_o           = cnt;
    fill_data_o          = mem_rdata_i;
    instr_cache_rep_en_o = (state == COMMIT);
    stall_f_o            = (state != IDLE) || instr_miss_f_i;
  end

  // Beat counter wraps naturally to 0 on the last beat of the line.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt          <= '0;
      fill_addr_o  <= '0;
      miss_count_o <= '0;
    end else begin
      unique case (state)
        IDLE: if (instr_miss_f_i) begin
          fill_addr_o <= pc_f_i & ~OFF_MASK;
          if (miss_count_o != 32'hFFFF_FFFF) miss_count_o <= miss_count_o + 32'd1;
        end
        REQ:  if (mem_gnt_i) cnt <= '0;
        FILL: if (mem_rvalid_i) cnt <= cnt + IDX_W'(1);
        default: ;
      endcase
    end
  end
endmodule
